// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the shift-and-add multiplier.
package mult_pkg;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/shift_add_mult16_if.sv
// Start/done handshake and operand/product bus between the ALU and the multiplier.
interface shift_add_mult16_if;
    import mult_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] P;

    modport master (output start, A, B, input ready, busy, done, P);
    modport slave  (input start, A, B, output ready, busy, done, P);
endinterface

// File: rtl/RCA16.sv
// 16-bit ripple-carry adder: S = A1 + A2 + in, carry-out on C.
module RCA16 (
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic        in,
    output logic [15:0] S,
    output logic        C
);
    always_comb begin
        logic c;
        c = in;
        S = '0;
        for (int i = 0; i < 16; i++) begin
            S[i] = A1[i] ^ A2[i] ^ c;
            c    = (A1[i] & A2[i]) | (c & (A1[i] ^ A2[i]));
        end
        C = c;
    end
endmodule

// File: rtl/shift_add_mult16.sv
// Sequential 16x16 unsigned multiplier: one gated partial product per clock,
// accumulated through RCA16 and shifted right into the {ACC,Q} pair.
module shift_add_mult16
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_add_mult16_if.slave   bus
);
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_p;
    state_t           r_state;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_addend = r_q[0] ? r_m : '0;

    RCA16 U_ADD (
        .A1 (r_acc),
        .A2 (w_addend),
        .in (1'b0),
        .S  (w_sum),
        .C  (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.A;
                        r_q     <= bus.B;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    // Carry-out becomes the new ACC MSB, so the 17-bit sum survives the shift.
                    r_acc <= {w_cout, w_sum[WIDTH-1:1]};
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_p     <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.busy  = (r_state == CALC) || (r_state == DONE);
    assign bus.done  = (r_state == DONE);
    assign bus.P     = r_p;
endmodule

// File: tb/tb_shift_add_mult16.sv
// Scoreboard bench for shift_add_mult16 driven by hand-computed directed vectors.
module tb_shift_add_mult16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_push = 0;

    typedef struct {
        logic [31:0] p;
        int          acc;
    } exp_t;
    exp_t sb[$];

    shift_add_mult16_if bus();

    shift_add_mult16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", bus.P, e.p);
                chk("latency", 32'(cyc - e.acc), 32'd16);
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!bus.ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input bit expect_done);
        exp_t e;
        wait_ready();
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        if (expect_done) begin
            e.p = exp;
            e.acc = cyc + 1;
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom();
        bus.B = $urandom();
    endtask

    task automatic wait_idle(output int busy_cycles);
        int g = 0;
        busy_cycles = 0;
        while (bus.busy && g < 60) begin
            busy_cycles++;
            @(negedge clk);
            g++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int nb;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #23;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_P", bus.P, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic product, latency and busy length.
        issue(16'd3, 16'd5, 32'h0000000F, 1'b1);
        wait_idle(nb);
        chk("busy_len", 32'(nb), 32'd17);

        // Carry-out kept on every iteration.
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        wait_idle(nb);

        // Zero operands; P holds the previous result during CALC.
        issue(16'h1234, 16'h0000, 32'h0, 1'b1);
        repeat (5) @(negedge clk);
        chk("P_hold_calc", bus.P, 32'hFFFE0001);
        wait_idle(nb);
        issue(16'h0000, 16'hBEEF, 32'h0, 1'b1);
        wait_idle(nb);
        repeat (3) @(negedge clk);
        chk("P_hold_idle", bus.P, 32'h0);

        // start re-pulsed mid-CALC must be ignored.
        issue(16'd7, 16'd9, 32'h0000003F, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.A = 16'd2;
        bus.B = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(nb);
        repeat (4) @(negedge clk);
        chk("P_after_ignored", bus.P, 32'h0000003F);

        // start held high: back-to-back acceptances 18 cycles apart.
        begin
            exp_t e;
            int first_acc;
            wait_ready();
            bus.start = 1'b1;
            bus.A = 16'h0100;
            bus.B = 16'h0100;
            first_acc = cyc + 1;
            e.p = 32'h00010000;
            e.acc = first_acc;
            sb.push_back(e);
            n_push++;
            @(negedge clk);
            wait_ready();
            chk("ii", 32'(cyc + 1 - first_acc), 32'd18);
            e.acc = cyc + 1;
            sb.push_back(e);
            n_push++;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (8) @(negedge clk);
            chk("P_between_done", bus.P, 32'h00010000);
            wait_idle(nb);
        end

        // Asynchronous reset at CALC cycle 8 aborts the operation.
        issue(16'h1234, 16'h5678, 32'h0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_P", bus.P, 32'h0);
        #3;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_P_after", bus.P, 32'h0);
        issue(16'h00FF, 16'h0101, 32'h0000FFFF, 1'b1);
        wait_idle(nb);
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'(n_push));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_add_mult16.md
# shift_add_mult16

Sequential 16×16 unsigned multiplier producing a 32-bit product by shift-and-add, one partial product per clock. Its datapath adder is an instance of the existing 16-bit ripple-carry adder `RCA16`, with carry-in tied low. The block sits directly downstream of `RCA16`, consuming its sum and carry-out every iteration, and feeds the ALU result mux through a start/done handshake.

## Interface
- `WIDTH`, default 16: operand width. Fixed at 16 to match `RCA16`; other values are unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `A`  in  16  multiplicand; captured on an accepted `start`.
- `B`  in  16  multiplier; captured on an accepted `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse; high exactly while in DONE.
- `P`  out  32  product register; valid from `done` until the next result is loaded.

## Operation
- Registers:
  - `M` (16): multiplicand.
  - `ACC` (16): upper accumulator.
  - `Q` (16): multiplier, becoming the low product half.
  - `CNT` (4): iteration count.
  - `P` (32): result.
  - `state` (2): FSM state.
- FSM states are IDLE, CALC and DONE.
  - IDLE → CALC on `start`=1. Same edge: `M`←`A`, `Q`←`B`, `ACC`←0, `CNT`←0.
  - CALC → CALC while `CNT`≠15.
  - CALC → DONE on the iteration with `CNT`=15.
  - DONE → IDLE unconditionally.
- CALC iteration, one per edge:
  - `RCA16` inputs: `A1`=`ACC`, `A2`=(`Q[0]` ? `M` : 0), `in`=0. Outputs are sum `S` and carry `C`.
  - `ACC`←{`C`, `S[15:1]`}.
  - `Q`←{`S[0]`, `Q[15:1]`}.
  - `CNT`←`CNT`+1.
- Width rule: the 17-bit {`C`,`S`} is never truncated before the shift, so no overflow is possible. The product is exact modulo 2^32 (max 0xFFFE0001).
- Result load: on the final iteration edge (`CNT`=15), `P`←{`C`, `S`, `Q[15:1]`}, i.e. the post-shift {`ACC`,`Q`}. This is the same edge that enters DONE.
- `P` is not modified in IDLE, CALC or DONE except at the result load.
- `start` is ignored in CALC and DONE. There is no queueing.
- If `start` is held high continuously, a new operation is accepted on the first IDLE edge after DONE.
- `A`/`B` may change freely after acceptance.
- Reset (asserted at any time, including mid-CALC):
  - Immediate return to IDLE.
  - `ACC`, `Q`, `M`, `CNT` and `P` cleared to 0.
  - Outputs: `ready`=1, `busy`=0, `done`=0.
  - The aborted operation produces no `done` and no `P` update.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `P`=0.
- `start` accepted at edge k:
  - CALC iterations occur at edges k+1 … k+16.
  - DONE holds between edges k+16 and k+17, with `done`=1 and `P` valid.
  - IDLE from edge k+17.
- Latency from the accepting edge to `done` is 16 cycles. Initiation interval is 18 cycles.
- `ready`, `busy` and `done` are decoded from `state` only, with no combinational path from `start`.
- Critical path: `Q[0]` → operand mux → `RCA16` 16-bit ripple → `ACC`/`Q`/`P` D-inputs.

## Structure
- Shared package `mult_pkg`: `WIDTH`=16, `CNT_W`=4, `LAST_ITER`=15, and the state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
- Unused encoding 2'b11 returns to IDLE.
- One sub-module: `RCA16` (instance name `U_ADD`), reused unchanged.
- Operand gating, shift and FSM live in this module. No further hierarchy.

## Test plan
- Reset, then `A`=3, `B`=5, `start` pulse → `done` 16 cycles after acceptance, `P`=0x0000000F, `busy` high for 17 cycles.
- `A`=0xFFFF, `B`=0xFFFF → `P`=0xFFFE0001. Also checks that the carry-out is kept on every iteration.
- `A`=0x1234, `B`=0 → `P`=0. Then `A`=0, `B`=0xBEEF → `P`=0. `P` holds between operations.
- `start` pulsed with `A`=7, `B`=9, then `start` re-pulsed with `A`=2, `B`=2 at cycle 5 of CALC → ignored; `P`=0x3F, exactly one `done`.
- `start` held high, operands 0x0100×0x0100 → `P`=0x00010000. Back-to-back acceptances 18 cycles apart; `P` unchanged between `done` pulses.
- `rst_n` asserted mid-CALC (cycle 8) for half a cycle → outputs immediately `ready`=1, `busy`=0, `P`=0. No `done` afterwards. A next operation 0x00FF×0x0101 → `P`=0x0000FFFF.
